// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: state encodings used by the transmitter and the future receiver.
package uart_tx_pkg;

  localparam int unsigned UART_CLKS_PER_BIT = 434;
  localparam int unsigned UART_STATE_W      = 3;

  typedef enum logic [UART_STATE_W-1:0] {
    UART_IDLE   = 3'd0,
    UART_START  = 3'd1,
    UART_DATA   = 3'd2,
    UART_PARITY = 3'd3,
    UART_STOP   = 3'd4
  } uartState_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit with a registered tick.
module uart_baud_counter
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             tick
);

  // tick is registered alongside count so it is high exactly when count == CLKS_PER_BIT-1
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (tick) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      count <= count + CNT_W'(1);
      tick  <= (count == CNT_W'(CLKS_PER_BIT - 2));
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 LSB first, one instance per channel.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enableTx,
  input  logic [DATA_BITS-1:0] dataIn,
  output logic                 busyTx,
  output logic                 tx,
  output logic                 doneTx
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  uartState_t           state;
  logic [DATA_BITS-1:0] shiftReg;
  logic [IDX_W-1:0]     bitIdx;
  logic [CNT_W-1:0]     baudCount;
  logic                 baudTick;
  logic                 baudClear;
`ifdef UART_TX_PARITY_EN
  logic                 parityBit;
`endif

  // Counter is held at zero in IDLE so every frame starts on a fresh bit period
  assign baudClear = (state == UART_IDLE);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uBaud (
    .clock(clock),
    .reset(reset),
    .clear(baudClear),
    .count(baudCount),
    .tick (baudTick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= UART_IDLE;
      tx       <= 1'b1;
      busyTx   <= 1'b0;
      doneTx   <= 1'b0;
      shiftReg <= '0;
      bitIdx   <= '0;
`ifdef UART_TX_PARITY_EN
      parityBit <= 1'b0;
`endif
    end else begin
      doneTx <= 1'b0;
      unique case (state)
        UART_IDLE: begin
          if (enableTx) begin
            shiftReg <= dataIn;
`ifdef UART_TX_PARITY_EN
            parityBit <= ^dataIn;
`endif
            state    <= UART_START;
            tx       <= 1'b0;
            busyTx   <= 1'b1;
          end
        end
        UART_START: begin
          if (baudTick) begin
            state  <= UART_DATA;
            bitIdx <= '0;
            tx     <= shiftReg[0];
          end
        end
        UART_DATA: begin
          if (baudTick) begin
            shiftReg <= shiftReg >> 1;
            if (bitIdx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state <= UART_PARITY;
              tx    <= parityBit;
`else
              state <= UART_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bitIdx <= bitIdx + IDX_W'(1);
              tx     <= shiftReg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        UART_PARITY: begin
          if (baudTick) begin
            state <= UART_STOP;
            tx    <= 1'b1;
          end
        end
`endif
        UART_STOP: begin
          // doneTx is set one cycle early so it is visible during the final stop-bit cycle
          if (baudTick) begin
            state  <= UART_IDLE;
            busyTx <= 1'b0;
          end else if (baudCount == CNT_W'(CLKS_PER_BIT - 2)) begin
            doneTx <= 1'b1;
          end
        end
        default: begin
          state  <= UART_IDLE;
          tx     <= 1'b1;
          busyTx <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at CLKS_PER_BIT=4; honours UART_TX_PARITY_EN.
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FLEN = NBITS * CPB;

  typedef struct {
    logic [7:0] data;
    int         startCycle;
  } frame_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enableTx = 1'b0;
  logic [7:0] dataIn = 8'h00;
  logic       busyTx, tx, doneTx;

  int tests = 0;
  int fails = 0;
  int cycleCnt = 0;
  int remain = 0;
  int accepts = 0;
  frame_t sbq[$];
  frame_t cur;
  bit inFrame = 1'b0;
  int pos = 0;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clock(clock), .reset(reset), .enableTx(enableTx), .dataIn(dataIn),
    .busyTx(busyTx), .tx(tx), .doneTx(doneTx)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  // Frame bit k: start, LSB-first data, optional even parity, stop
  function automatic logic expBit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (NBITS == 11 && k == 9) return ^d;
    return 1'b1;
  endfunction

  // Reference model: a request is accepted whenever no frame is outstanding
  always @(posedge clock) begin
    cycleCnt++;
    if (!reset) begin
      remain = 0;
      sbq.delete();
    end else if (remain > 0) begin
      remain--;
    end else if (enableTx) begin
      sbq.push_back('{data: dataIn, startCycle: cycleCnt});
      remain = FLEN;
      accepts++;
    end
  end

  task automatic checkFrameCycle();
    check("frameLines", int'({tx, busyTx, doneTx}),
          int'({expBit(cur.data, pos / CPB), 1'b1, (pos == FLEN - 1)}));
    pos++;
    if (pos == FLEN) inFrame = 1'b0;
  endtask

  // Monitor: compares the line every cycle against the frame popped from the scoreboard
  always @(negedge clock) begin
    if (!reset) begin
      inFrame = 1'b0;
    end else if (!inFrame) begin
      if (tx == 1'b0 || busyTx) begin
        if (sbq.size() == 0) begin
          check("unexpectedFrame", 1, 0);
        end else begin
          cur = sbq.pop_front();
          check("startCycle", cycleCnt, cur.startCycle);
          inFrame = 1'b1;
          pos = 0;
          checkFrameCycle();
        end
      end else begin
        check("idleDone", int'(doneTx), 0);
        if (sbq.size() > 0 && cycleCnt > sbq[0].startCycle) begin
          check("missingFrame", cycleCnt, sbq[0].startCycle);
          void'(sbq.pop_front());
        end
      end
    end else begin
      checkFrameCycle();
    end
  end

  task automatic sendPulse(input logic [7:0] d);
    @(posedge clock); #1;
    enableTx = 1'b1;
    dataIn = d;
    @(posedge clock); #1;
    enableTx = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 4 * FLEN; i++) begin
      @(posedge clock); #1;
      if (remain == 0) return;
    end
    check("waitIdleTimeout", remain, 0);
  endtask

  task automatic waitAccepts(input int target);
    for (int i = 0; i < 4 * FLEN; i++) begin
      @(posedge clock); #1;
      if (accepts >= target) return;
    end
    check("waitAcceptTimeout", accepts, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cycleCnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("resetTx", int'(tx), 1);
    check("resetBusy", int'(busyTx), 0);
    check("resetDone", int'(doneTx), 0);
    @(posedge clock); #2 reset = 1'b1;
    repeat (20) @(posedge clock);

    sendPulse(8'hA5);
    waitIdle();

    // Second request while busy must be ignored
    a0 = accepts;
    sendPulse(8'h3C);
    repeat (8) @(posedge clock);
    #1 enableTx = 1'b1; dataIn = 8'hFF;
    @(posedge clock); #1 enableTx = 1'b0;
    waitIdle();
    repeat (3) @(posedge clock);
    check("busyIgnored", accepts - a0, 1);

    // Held enable: back-to-back frames, second carries data present at re-acceptance
    a0 = accepts;
    @(posedge clock); #1 enableTx = 1'b1; dataIn = 8'h01;
    waitAccepts(a0 + 1);
    repeat (5) @(posedge clock);
    #1 dataIn = 8'h80;
    waitAccepts(a0 + 2);
    enableTx = 1'b0;
    waitIdle();
    check("backToBack", accepts - a0, 2);

    // Reset during data bit 3 aborts asynchronously
    sendPulse(8'h00);
    repeat (16) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("abortTx", int'(tx), 1);
    check("abortBusy", int'(busyTx), 0);
    check("abortDone", int'(doneTx), 0);
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    sendPulse(8'h5A);
    waitIdle();

    sendPulse(8'h07);
    waitIdle();
    sendPulse(8'h03);
    waitIdle();

    for (int i = 0; i < 800; i++) begin
      @(posedge clock); #1;
      enableTx = ($urandom_range(0, 5) == 0);
      dataIn = 8'($urandom);
    end
    enableTx = 1'b0;
    waitIdle();
    repeat (4) @(posedge clock);
    #1;
    check("scoreboardEmpty", sbq.size(), 0);
    check("endIdleBusy", int'(busyTx), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
